// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN       = 32;
  localparam int unsigned WORD_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] instr;
    logic [FETCH_XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {instr, pc} entries; flush beats push, pop is always honoured.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wdata,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = ptr_inc(wr_q);
      if (pop)  rd_d = ptr_inc(rd_q);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (push && !flush) mem_q[wr_q] <= wdata;
    end
  end

  assign count = cnt_q;
  assign head  = mem_q[rd_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, 1-cycle-latency imem requests, buffered words presented to decode
// via valid/ready, with branch redirect flushing buffered and in-flight words.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned           BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  PCSrc,
  input  logic [DATA_WIDTH-1:0] BranchTarget,
  input  logic                  dec_ready,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] Instr,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] PCPlus4
);

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  inflight_q, inflight_d;
  logic                  head_valid, pop, push, kill, issue;
  logic [CW-1:0]         count;
  logic [CW:0]           occupancy;
  fetch_entry_t          head, wdata;

  assign head_valid = !reset && (count != '0);
  assign pop        = head_valid && dec_ready;
  // A redirect or reset in the response cycle drops the word arriving from imem.
  assign kill       = reset || PCSrc;
  assign push       = inflight_q && !kill;
  assign occupancy  = (CW+1)'(count) + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue      = !kill && (occupancy < (CW+1)'(BUF_DEPTH));
  assign wdata      = '{instr: imem_rdata, pc: inflight_pc_q};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    if (PCSrc) begin
      fetch_pc_d = BranchTarget & ~DATA_WIDTH'(WORD_BYTES - 1);
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + DATA_WIDTH'(WORD_BYTES);
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (PCSrc),
    .wdata (wdata),
    .count (count),
    .head  (head)
  );

  assign imem_req    = issue;
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = head_valid;
  assign Instr       = head_valid ? head.instr : '0;
  assign PC          = head_valid ? head.pc : '0;
  assign PCPlus4     = head_valid ? head.pc + DATA_WIDTH'(WORD_BYTES) : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, stall, redirect, wrap and reset scenarios.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, PCSrc, dec_ready;
  logic [31:0] BranchTarget;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, imem_rdata, Instr, PC, PCPlus4;

  logic        w_PCSrc, w_dec_ready;
  logic [31:0] w_target;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_rdata, w_Instr, w_PC, w_PCPlus4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Instruction memories with fixed 1-cycle latency; unrequested cycles return junk.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? tag(imem_addr) : 32'hBAD0_BAD0;
    w_rdata    <= w_req ? tag(w_addr) : 32'hBAD0_BAD0;
  end

  instr_fetch_unit #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0),
    .BUF_DEPTH (2)
  ) dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
    .dec_ready(dec_ready), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .Instr(Instr),
    .PC(PC), .PCPlus4(PCPlus4)
  );

  instr_fetch_unit #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'hFFFF_FFF8),
    .BUF_DEPTH (2)
  ) dut_w (
    .clk(clk), .reset(reset), .PCSrc(w_PCSrc), .BranchTarget(w_target),
    .dec_ready(w_dec_ready), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .instr_valid(w_valid), .Instr(w_Instr),
    .PC(w_PC), .PCPlus4(w_PCPlus4)
  );

  // Leaves the bench at the falling edge of the first cycle after reset.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; PCSrc = 1'b0; dec_ready = 1'b1; BranchTarget = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; PCSrc = 1'b0; dec_ready = 1'b1; BranchTarget = '0;
    @(negedge clk);
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: req=%b valid=%b expected 0 0", imem_req, instr_valid);
    end
    n_checks++;
    if (Instr !== 32'h0 || PC !== 32'h0 || PCPlus4 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: Instr=%h PC=%h PCPlus4=%h expected all 0", Instr, PC, PCPlus4);
    end
    n_checks++;
    if (w_req !== 1'b0 || w_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl_w: req=%b valid=%b expected 0 0", w_req, w_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_req: req=%b addr=%h valid=%b expected 1 00000000 0",
               imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      #1;
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
        n_fail++;
        $display("FAIL stream_req k=%0d: req=%b addr=%h expected 1 %h", k, imem_req, imem_addr, 32'(4 * k));
      end
      n_checks++;
      if (k < 2) begin
        if (instr_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_latency k=%0d: valid=%b expected 0", k, instr_valid);
        end
      end else begin
        exp_pc = 32'(4 * (k - 2));
        if (instr_valid !== 1'b1 || PC !== exp_pc || Instr !== tag(exp_pc) || PCPlus4 !== exp_pc + 32'd4) begin
          n_fail++;
          $display("FAIL stream_out k=%0d: valid=%b PC=%h Instr=%h PCPlus4=%h expected 1 %h %h %h",
                   k, instr_valid, PC, Instr, PCPlus4, exp_pc, tag(exp_pc), exp_pc + 32'd4);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    do_reset();
    repeat (4) @(negedge clk);
    dec_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b1 || PC !== 32'h8 || Instr !== tag(32'h8)) begin
        n_fail++;
        $display("FAIL stall_hold c=%0d: req=%b valid=%b PC=%h Instr=%h expected 0 1 00000008 %h",
                 c, imem_req, instr_valid, PC, Instr, tag(32'h8));
      end
      @(negedge clk);
    end
    dec_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      exp_pc = 32'(8 + 4 * j);
      n_checks++;
      if (instr_valid !== 1'b1 || PC !== exp_pc || Instr !== tag(exp_pc) ||
          imem_req !== 1'b1 || imem_addr !== 32'(16 + 4 * j)) begin
        n_fail++;
        $display("FAIL stall_resume j=%0d: valid=%b PC=%h Instr=%h req=%b addr=%h expected 1 %h %h 1 %h",
                 j, instr_valid, PC, Instr, imem_req, imem_addr, exp_pc, tag(exp_pc), 32'(16 + 4 * j));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    dec_ready = 1'b0;
    repeat (3) @(negedge clk);
    PCSrc = 1'b1; BranchTarget = 32'h0000_0103;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b1 || PC !== 32'h0) begin
      n_fail++;
      $display("FAIL redir_cycle: req=%b valid=%b PC=%h expected 0 1 00000000", imem_req, instr_valid, PC);
    end
    @(negedge clk);
    PCSrc = 1'b0; dec_ready = 1'b1;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL redir_r1: valid=%b req=%b addr=%h expected 0 1 00000100", instr_valid, imem_req, imem_addr);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h104) begin
      n_fail++;
      $display("FAIL redir_r2: valid=%b req=%b addr=%h expected 0 1 00000104", instr_valid, imem_req, imem_addr);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (instr_valid !== 1'b1 || PC !== 32'h100 || Instr !== tag(32'h100) || PCPlus4 !== 32'h104) begin
      n_fail++;
      $display("FAIL redir_r3: valid=%b PC=%h Instr=%h PCPlus4=%h expected 1 00000100 %h 00000104",
               instr_valid, PC, Instr, PCPlus4, tag(32'h100));
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (instr_valid !== 1'b1 || PC !== 32'h104) begin
      n_fail++;
      $display("FAIL redir_r4: valid=%b PC=%h expected 1 00000104", instr_valid, PC);
    end
  endtask

  task automatic test_redirect_pop();
    do_reset();
    repeat (4) @(negedge clk);
    PCSrc = 1'b1; BranchTarget = 32'h0000_0200;
    #1;
    n_checks++;
    if (instr_valid !== 1'b1 || PC !== 32'h8 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rpop_cycle: valid=%b PC=%h req=%b expected 1 00000008 0", instr_valid, PC, imem_req);
    end
    @(negedge clk);
    PCSrc = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'(32'h200 + 4 * c)) begin
        n_fail++;
        $display("FAIL rpop_gap c=%0d: valid=%b PC=%h req=%b addr=%h expected 0 - 1 %h",
                 c, instr_valid, PC, imem_req, imem_addr, 32'(32'h200 + 4 * c));
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (instr_valid !== 1'b1 || PC !== 32'h200 || Instr !== tag(32'h200)) begin
      n_fail++;
      $display("FAIL rpop_target: valid=%b PC=%h Instr=%h expected 1 00000200 %h",
               instr_valid, PC, Instr, tag(32'h200));
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (3) @(negedge clk);
    PCSrc = 1'b1; BranchTarget = 32'h0000_0300;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: req=%b expected 0", imem_req);
    end
    @(negedge clk);
    BranchTarget = 32'h0000_0407;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: req=%b valid=%b expected 0 0", imem_req, instr_valid);
    end
    @(negedge clk);
    PCSrc = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h404 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_target: req=%b addr=%h valid=%b expected 1 00000404 0", imem_req, imem_addr, instr_valid);
    end
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (instr_valid !== 1'b1 || PC !== 32'h404 || PCPlus4 !== 32'h408) begin
      n_fail++;
      $display("FAIL b2b_out: valid=%b PC=%h PCPlus4=%h expected 1 00000404 00000408", instr_valid, PC, PCPlus4);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [5];
    logic [31:0] exp_pc   [5];
    logic [31:0] exp_pc4  [5];
    exp_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
    exp_pc   = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    exp_pc4  = '{32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (w_req !== 1'b1 || w_addr !== exp_addr[k]) begin
        n_fail++;
        $display("FAIL wrap_req k=%0d: req=%b addr=%h expected 1 %h", k, w_req, w_addr, exp_addr[k]);
      end
      if (k >= 2) begin
        n_checks++;
        if (w_valid !== 1'b1 || w_PC !== exp_pc[k] || w_PCPlus4 !== exp_pc4[k] || w_Instr !== tag(exp_pc[k])) begin
          n_fail++;
          $display("FAIL wrap_out k=%0d: valid=%b PC=%h PCPlus4=%h Instr=%h expected 1 %h %h %h",
                   k, w_valid, w_PC, w_PCPlus4, w_Instr, exp_pc[k], exp_pc4[k], tag(exp_pc[k]));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (4) @(negedge clk);
    reset = 1'b1; PCSrc = 1'b1; BranchTarget = 32'h0000_0500;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0 || PC !== 32'h0) begin
      n_fail++;
      $display("FAIL rmid_during: valid=%b req=%b PC=%h expected 0 0 00000000", instr_valid, imem_req, PC);
    end
    @(negedge clk);
    reset = 1'b0; PCSrc = 1'b0;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rmid_restart: valid=%b req=%b addr=%h expected 0 1 00000000", instr_valid, imem_req, imem_addr);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h4) begin
      n_fail++;
      $display("FAIL rmid_stale: valid=%b addr=%h expected 0 00000004", instr_valid, imem_addr);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (instr_valid !== 1'b1 || PC !== 32'h0 || Instr !== tag(32'h0)) begin
      n_fail++;
      $display("FAIL rmid_first: valid=%b PC=%h Instr=%h expected 1 00000000 %h", instr_valid, PC, Instr, tag(32'h0));
    end
  endtask

  initial begin
    reset = 1'b1; PCSrc = 1'b0; dec_ready = 1'b1; BranchTarget = '0;
    w_PCSrc = 1'b0; w_dec_ready = 1'b1; w_target = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_pop();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
